// File: rtl/grid_frame_serializer.sv
// Snapshots the cell grid on each generation tick and streams it out one row per beat
// over valid/ready. Also tracks generation count, extinct/still-life status and dropped ticks.
module grid_frame_serializer #(
  parameter int unsigned ROWS  = 8,
  parameter int unsigned COLS  = 8,
  parameter int unsigned GEN_W = 16,
  localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 _rst,
  input  logic [ROWS*COLS-1:0] grid_in,
  input  logic                 gen_tick,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [COLS-1:0]      out_data,
  output logic [RW-1:0]        out_row,
  output logic                 out_last,
  output logic [GEN_W-1:0]     gen_count,
  output logic                 extinct,
  output logic                 still_life,
  output logic [7:0]           drop_count
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                state_q;
  logic [ROWS*COLS-1:0]  snap_q;
  logic [ROWS*COLS-1:0]  prev_q;
  logic                  first_q;
  logic                  prev_valid_q;

  logic                  accept;
  logic                  capture;
  logic [RW-1:0]         row_nxt;
  logic [COLS-1:0]       beat_nxt;

  assign accept   = out_valid & out_ready;
  // A tick landing on the accepted last beat chains straight into the next frame.
  assign capture  = gen_tick & ((state_q == StIdle) | (accept & out_last));
  assign row_nxt  = out_row + RW'(1);
  assign beat_nxt = snap_q[row_nxt*COLS +: COLS];

  // prev only holds a real snapshot once two frames have been captured.
  assign still_life = prev_valid_q && (snap_q == prev_q);

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state_q      <= StIdle;
      snap_q       <= '0;
      prev_q       <= '0;
      first_q      <= 1'b1;
      prev_valid_q <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_row      <= '0;
      out_last     <= 1'b0;
      gen_count    <= '0;
      extinct      <= 1'b0;
      drop_count   <= '0;
    end else begin
      if (gen_tick) begin
        gen_count <= gen_count + GEN_W'(1);
      end

      if (capture) begin
        snap_q       <= grid_in;
        prev_q       <= snap_q;
        prev_valid_q <= !first_q;
        first_q      <= 1'b0;
        extinct      <= (grid_in == '0);
        state_q      <= StSend;
        out_valid    <= 1'b1;
        out_row      <= '0;
        out_data     <= grid_in[COLS-1:0];
        out_last     <= (ROWS == 1);
      end else if (state_q == StSend) begin
        if (gen_tick && (drop_count != 8'hFF)) begin
          drop_count <= drop_count + 8'd1;
        end
        if (accept) begin
          if (out_last) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end else begin
            out_row  <= row_nxt;
            out_data <= beat_nxt;
            out_last <= (row_nxt == RW'(ROWS - 1));
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_grid_frame_serializer.sv
// Directed self-checking bench for grid_frame_serializer (8x8 grid, 16-bit generation count).
module tb_grid_frame_serializer;

  localparam logic [63:0] BLOCK = 64'h0000_0018_1800_0000;

  logic        clk;
  logic        _rst;
  logic [63:0] grid_in;
  logic        gen_tick;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [2:0]  out_row;
  logic        out_last;
  logic [15:0] gen_count;
  logic        extinct;
  logic        still_life;
  logic [7:0]  drop_count;

  int          checks;
  int          errors;
  logic [15:0] exp_gen;

  grid_frame_serializer #(
    .ROWS (8),
    .COLS (8),
    .GEN_W(16)
  ) dut (
    .clk       (clk),
    ._rst      (_rst),
    .grid_in   (grid_in),
    .gen_tick  (gen_tick),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_last  (out_last),
    .gen_count (gen_count),
    .extinct   (extinct),
    .still_life(still_life),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic [63:0] g);
    grid_in  = g;
    gen_tick = 1'b1;
    step();
    gen_tick = 1'b0;
    exp_gen  = exp_gen + 16'd1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (out_valid && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: out_valid=%b still high after %0d cycles, expected 0", out_valid, n);
    end
  endtask

  task automatic test_reset();
    _rst = 1'b0;
    repeat (2) step();
    checks++;
    if ({out_valid, out_data, out_row, out_last, gen_count, extinct, still_life, drop_count}
        !== '0) begin
      errors++;
      $display("FAIL reset_state: v=%b d=%h r=%0d l=%b g=%h e=%b s=%b dc=%0d, expected all 0",
               out_valid, out_data, out_row, out_last, gen_count, extinct, still_life,
               drop_count);
    end
    _rst = 1'b1;
    exp_gen = '0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_frame_basic();
    logic [7:0] e;
    out_ready = 1'b1;
    tick(BLOCK);
    for (int i = 0; i < 8; i++) begin
      e = (i == 3 || i == 4) ? 8'h18 : 8'h00;
      checks++;
      if (out_valid !== 1'b1 || out_row !== 3'(i) || out_data !== e || out_last !== (i == 7))
      begin
        errors++;
        $display("FAIL basic_beat%0d: v=%b row=%0d data=%h last=%b, expected 1/%0d/%h/%b",
                 i, out_valid, out_row, out_data, out_last, i, e, (i == 7));
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_end: out_valid=%b expected 0", out_valid);
    end
    checks++;
    if (gen_count !== 16'd1 || extinct !== 1'b0 || still_life !== 1'b0) begin
      errors++;
      $display("FAIL basic_flags: gen=%0d ext=%b still=%b, expected 1/0/0",
               gen_count, extinct, still_life);
    end
  endtask

  task automatic test_still_extinct();
    tick(BLOCK);
    checks++;
    if (still_life !== 1'b1 || extinct !== 1'b0 || gen_count !== 16'd2) begin
      errors++;
      $display("FAIL still_life: still=%b ext=%b gen=%0d, expected 1/0/2",
               still_life, extinct, gen_count);
    end
    drain();
    tick(64'h0);
    checks++;
    if (still_life !== 1'b0 || extinct !== 1'b1 || gen_count !== 16'd3) begin
      errors++;
      $display("FAIL extinct: still=%b ext=%b gen=%0d, expected 0/1/3",
               still_life, extinct, gen_count);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int beats;
    int stall;
    logic done;
    beats = 0;
    stall = 0;
    done  = 1'b0;
    out_ready = 1'b1;
    tick(64'h0807_0605_0403_0201);
    for (int c = 0; c < 40 && !done; c++) begin
      if (beats == 2 && stall < 5) begin
        out_ready = 1'b0;
        stall++;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid) begin
        checks++;
        if (out_row !== 3'(beats) || out_data !== 8'(beats + 1)) begin
          errors++;
          $display("FAIL bp_beat: row=%0d data=%h, expected %0d/%h (stall=%0d)",
                   out_row, out_data, beats, 8'(beats + 1), stall);
        end
        if (out_ready) begin
          beats++;
          if (out_last) done = 1'b1;
        end
      end
      step();
    end
    out_ready = 1'b1;
    checks++;
    if (beats != 8 || stall != 5 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_count: beats=%0d stall=%0d v=%b, expected 8/5/0",
               beats, stall, out_valid);
    end
    checks++;
    if (gen_count !== exp_gen) begin
      errors++;
      $display("FAIL bp_gen: gen=%0d expected %0d", gen_count, exp_gen);
    end
  endtask

  task automatic test_last_beat_tick();
    out_ready = 1'b1;
    tick(BLOCK);
    for (int c = 0; c < 10 && !out_last; c++) step();
    checks++;
    if (out_last !== 1'b1 || out_row !== 3'd7) begin
      errors++;
      $display("FAIL chain_reach_last: last=%b row=%0d, expected 1/7", out_last, out_row);
    end
    grid_in  = 64'h0000_0000_0000_00FF;
    gen_tick = 1'b1;
    step();
    gen_tick = 1'b0;
    exp_gen  = exp_gen + 16'd1;
    checks++;
    if (out_valid !== 1'b1 || out_row !== 3'd0 || out_data !== 8'hFF) begin
      errors++;
      $display("FAIL chain_row0: v=%b row=%0d data=%h, expected 1/0/ff",
               out_valid, out_row, out_data);
    end
    checks++;
    if (drop_count !== 8'd0 || gen_count !== exp_gen || still_life !== 1'b0
        || extinct !== 1'b0) begin
      errors++;
      $display("FAIL chain_flags: drop=%0d gen=%0d still=%b ext=%b, expected 0/%0d/0/0",
               drop_count, gen_count, still_life, extinct, exp_gen);
    end
    step();
    checks++;
    if (out_row !== 3'd1 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL chain_row1: row=%0d data=%h, expected 1/00", out_row, out_data);
    end
    drain();
  endtask

  task automatic test_overrun();
    out_ready = 1'b1;
    tick(64'hF0E0_D0C0_B0A0_9080);
    step();
    out_ready = 1'b0;
    tick(64'hFFFF_FFFF_FFFF_FFFF);
    checks++;
    if (drop_count !== 8'd1 || gen_count !== exp_gen || out_row !== 3'd1
        || out_data !== 8'h90) begin
      errors++;
      $display("FAIL overrun_one: drop=%0d gen=%0d row=%0d data=%h, expected 1/%0d/1/90",
               drop_count, gen_count, out_row, out_data, exp_gen);
    end
    for (int i = 0; i < 299; i++) tick(64'hFFFF_FFFF_FFFF_FFFF);
    checks++;
    if (drop_count !== 8'd255 || gen_count !== exp_gen) begin
      errors++;
      $display("FAIL overrun_sat: drop=%0d gen=%0d, expected 255/%0d",
               drop_count, gen_count, exp_gen);
    end
    out_ready = 1'b1;
    for (int r = 1; r < 8; r++) begin
      checks++;
      if (out_valid !== 1'b1 || out_row !== 3'(r) || out_data !== 8'(8'h80 + 8'h10 * r)) begin
        errors++;
        $display("FAIL overrun_snap: v=%b row=%0d data=%h, expected 1/%0d/%h",
                 out_valid, out_row, out_data, r, 8'(8'h80 + 8'h10 * r));
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0 || extinct !== 1'b0 || still_life !== 1'b0) begin
      errors++;
      $display("FAIL overrun_end: v=%b ext=%b still=%b, expected 0/0/0",
               out_valid, extinct, still_life);
    end
  endtask

  task automatic test_reset_midframe();
    out_ready = 1'b1;
    tick(BLOCK);
    for (int c = 0; c < 10 && out_row != 3'd5; c++) step();
    #2;
    _rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, out_row, out_last, gen_count, extinct, still_life, drop_count}
        !== '0) begin
      errors++;
      $display("FAIL async_reset: v=%b d=%h r=%0d l=%b g=%h e=%b s=%b dc=%0d, expected all 0",
               out_valid, out_data, out_row, out_last, gen_count, extinct, still_life,
               drop_count);
    end
    step();
    _rst = 1'b1;
    exp_gen = '0;
    step();
    tick(BLOCK);
    checks++;
    if (still_life !== 1'b0 || gen_count !== 16'd1 || out_valid !== 1'b1
        || out_row !== 3'd0) begin
      errors++;
      $display("FAIL post_reset: still=%b gen=%0d v=%b row=%0d, expected 0/1/1/0",
               still_life, gen_count, out_valid, out_row);
    end
    drain();
  endtask

  task automatic test_gen_wrap();
    out_ready = 1'b1;
    grid_in   = BLOCK;
    gen_tick  = 1'b1;
    repeat (65534) step();
    gen_tick  = 1'b0;
    exp_gen   = exp_gen + 16'd65534;
    checks++;
    if (gen_count !== 16'hFFFF || gen_count !== exp_gen) begin
      errors++;
      $display("FAIL gen_preload: gen=%h expected ffff", gen_count);
    end
    drain();
    tick(BLOCK);
    checks++;
    if (gen_count !== 16'h0000) begin
      errors++;
      $display("FAIL gen_wrap: gen=%h expected 0000", gen_count);
    end
    drain();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_gen   = '0;
    _rst      = 1'b0;
    grid_in   = '0;
    gen_tick  = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_frame_basic();
    test_still_extinct();
    test_backpressure();
    test_last_beat_tick();
    test_overrun();
    test_reset_midframe();
    test_gen_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
